gamma_pipe: RTL and testbench

- Multi-channel, pipelined gamma correction stage between the pixel framebuffer read path and the PWM/bit-plane output logic.
- Each channel owns a runtime-writable lookup table of 2**IN_BITS entries with 8-bit values.
- After reset, every table auto-fills with an identity ramp. Host software then overwrites it with a real curve.
- Pixels flow through a valid/ready pipeline with a per-pixel bypass mode.

---
 rtl/gamma_pkg.sv | 34 +++
 rtl/gamma_lut_ram.sv | 43 ++++
 rtl/gamma_pipe.sv | 168 ++++++++++++++++
 tb/tb_gamma_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// ============================================================================
// Module  : gamma_pkg
// Brief   : Shared types and helpers for the gamma correction pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gamma_pkg;

    localparam int LUT_W = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // MSB-first bit replication of value[in_w-1:0] into out_w bits; truncates to
    // the top out_w bits when out_w < in_w. Result is right-aligned.
    function automatic logic [7:0] replicate(input logic [7:0] value,
                                             input int in_w,
                                             input int out_w);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < out_w) begin
                res[out_w - 1 - i] = value[in_w - 1 - (i % in_w)];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gamma_lut_ram.sv
// ============================================================================
// Module  : gamma_lut_ram
// Brief   : One-channel synchronous LUT RAM, read-enable, read-before-write.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gamma_lut_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = mem[raddr];
    end

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/gamma_pipe.sv
// ============================================================================
// Module  : gamma_pipe
// Brief   : Multi-channel 2-stage gamma LUT pipeline with per-pixel bypass.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gamma_pipe
    import gamma_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int IN_BITS  = 5,
    parameter int OUT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*IN_BITS-1:0]  in_pixel,
    input  logic                         in_bypass,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_BITS-1:0] out_pixel,
    input  logic                         lut_we,
    input  logic [CHANNELS-1:0]          lut_chan_mask,
    input  logic [IN_BITS-1:0]           lut_addr,
    input  logic [LUT_W-1:0]             lut_data,
    output logic                         lut_busy
);

    localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'((2**IN_BITS) - 1);

    state_e                       state_q, state_d;
    logic [IN_BITS-1:0]           fill_addr_q, fill_addr_d;
    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_bypass_q, s1_bypass_d;
    logic [CHANNELS*IN_BITS-1:0]  s1_pixel_q, s1_pixel_d;
    logic                         out_valid_q, out_valid_d;
    logic [CHANNELS*OUT_BITS-1:0] out_pixel_q, out_pixel_d;

    logic                         stall;
    logic                         accept;
    logic [LUT_W-1:0]             fill_val;
    logic [CHANNELS-1:0]          ram_we;
    logic [IN_BITS-1:0]           ram_waddr;
    logic [LUT_W-1:0]             ram_wdata;
    logic [LUT_W-1:0]             rd_data [CHANNELS];
    logic [CHANNELS*OUT_BITS-1:0] result;

    assign stall     = out_valid_q && !out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        case (state_q)
            ST_INIT: begin
                fill_addr_d = fill_addr_q + IN_BITS'(1);
                if (fill_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        fill_val                = '0;
        fill_val[IN_BITS-1:0]   = fill_addr_q;
    end

    // INIT owns the write port for the ramp fill; host writes are ignored there.
    always_comb begin
        lut_busy  = 1'b1;
        in_ready  = 1'b0;
        ram_we    = '0;
        ram_waddr = fill_addr_q;
        ram_wdata = replicate(fill_val, IN_BITS, LUT_W);
        case (state_q)
            ST_INIT: ram_we = '1;
            ST_RUN: begin
                lut_busy  = 1'b0;
                in_ready  = !stall;
                ram_we    = lut_we ? lut_chan_mask : '0;
                ram_waddr = lut_addr;
                ram_wdata = lut_data;
            end
            default: ;
        endcase
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [LUT_W-1:0] raw_ext;
        logic [LUT_W-1:0] byp_full;

        always_comb begin
            raw_ext              = '0;
            raw_ext[IN_BITS-1:0] = s1_pixel_q[c*IN_BITS +: IN_BITS];
        end

        assign byp_full = replicate(raw_ext, IN_BITS, OUT_BITS);
        assign result[c*OUT_BITS +: OUT_BITS] = s1_bypass_q ? byp_full[OUT_BITS-1:0]
                                                            : rd_data[c][LUT_W-1 -: OUT_BITS];

        gamma_lut_ram #(
            .ADDR_W (IN_BITS),
            .DATA_W (LUT_W)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[c]),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .re    (!stall),
            .raddr (in_pixel[c*IN_BITS +: IN_BITS]),
            .rdata (rd_data[c])
        );
    end

    // The RAM read enable tracks !stall, so stage 1 and its RAM word freeze together.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_bypass_d = s1_bypass_q;
        s1_pixel_d  = s1_pixel_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        if (!stall) begin
            s1_valid_d  = accept;
            s1_bypass_d = in_bypass;
            s1_pixel_d  = in_pixel;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_pixel_d = result;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_pixel_q  <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_bypass_q <= s1_bypass_d;
            s1_pixel_q  <= s1_pixel_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gamma_pipe.sv
// ============================================================================
// Module  : tb_gamma_pipe
// Brief   : Scoreboard bench for gamma_pipe with a table-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gamma_pipe;

    localparam int CH = 3;
    localparam int IB = 5;
    localparam int OB = 8;
    localparam int PW = CH * IB;
    localparam int OW = CH * OB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          in_bypass;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_pixel;
    logic          lut_we;
    logic [CH-1:0] lut_chan_mask;
    logic [IB-1:0] lut_addr;
    logic [7:0]    lut_data;
    logic          lut_busy;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    logic [OW-1:0] exp_q[$];
    int            lut_m [CH][2**IB];
    logic          hold_valid = 1'b0;
    logic [OW-1:0] hold_pix;
    logic [OW-1:0] exp_pix;
    logic [OW-1:0] got_exp;

    gamma_pipe #(
        .CHANNELS (CH),
        .IN_BITS  (IB),
        .OUT_BITS (OB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .in_bypass     (in_bypass),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pixel     (out_pixel),
        .lut_we        (lut_we),
        .lut_chan_mask (lut_chan_mask),
        .lut_addr      (lut_addr),
        .lut_data      (lut_data),
        .lut_busy      (lut_busy)
    );

    always #5 clk = ~clk;

    // Concatenate v with itself until at least ow bits exist, keep the top ow.
    function automatic int rep(input int v, input int iw, input int ow);
        int r = 0;
        int b = 0;
        while (b < ow) begin
            r = (r << iw) | v;
            b += iw;
        end
        return r >> (b - ow);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle where the handshake is settled.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            hold_valid = 1'b0;
            for (int c = 0; c < CH; c++)
                for (int a = 0; a < 2**IB; a++)
                    lut_m[c][a] = rep(a, IB, 8);
        end else begin
            if (hold_valid) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_pixel_hold", out_pixel, hold_pix);
            end
            if (out_valid && !out_ready) begin
                check("in_ready_in_stall", in_ready, 0);
                stall_cycles++;
            end
            hold_valid = out_valid && !out_ready;
            hold_pix   = out_pixel;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", out_pixel);
                end else begin
                    got_exp = exp_q.pop_front();
                    check("out_pixel", out_pixel, got_exp);
                end
            end
            if (in_valid && in_ready) begin
                exp_pix = '0;
                for (int c = 0; c < CH; c++) begin
                    int v;
                    int r;
                    v = int'((in_pixel >> (c * IB)) & ((1 << IB) - 1));
                    r = in_bypass ? rep(v, IB, OB) : (lut_m[c][v] >> (8 - OB));
                    exp_pix[c*OB +: OB] = OB'(r);
                end
                exp_q.push_back(exp_pix);
            end
            if (lut_we && !lut_busy) begin
                for (int c = 0; c < CH; c++)
                    if (lut_chan_mask[c]) lut_m[c][lut_addr] = int'(lut_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] pix, input logic byp);
        int n = 0;
        in_valid  = 1'b1;
        in_pixel  = pix;
        in_bypass = byp;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        cyc();
        in_valid = 1'b0;
    endtask

    // Release reset and measure the ramp fill window.
    task automatic do_init();
        int busy_cnt = 0;
        int ir_bad   = 0;
        int n        = 0;
        cyc();
        reset_n = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            if (!lut_busy) break;
            busy_cnt++;
            if (in_ready) ir_bad++;
            n++;
        end
        check("init_busy_cycles", busy_cnt, 32);
        check("init_in_ready_low", ir_bad, 0);
        check("run_busy_low", lut_busy, 0);
        check("run_in_ready", in_ready, 1);
        cyc();
    endtask

    task automatic write_lut(input logic [IB-1:0] a, input logic [7:0] d, input logic [CH-1:0] m);
        lut_we        = 1'b1;
        lut_addr      = a;
        lut_data      = d;
        lut_chan_mask = m;
        cyc();
        lut_we = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] pixs [8];
        int idx;
        int k;

        reset_n       = 1'b0;
        in_valid      = 1'b0;
        in_pixel      = '0;
        in_bypass     = 1'b0;
        out_ready     = 1'b1;
        lut_we        = 1'b0;
        lut_chan_mask = '0;
        lut_addr      = '0;
        lut_data      = '0;
        repeat (3) cyc();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pixel", out_pixel, 0);
        check("reset_lut_busy", lut_busy, 1);

        do_init();

        // Ramp lookup and two-cycle latency.
        send({5'd1, 5'd16, 5'd31}, 1'b0);
        check("latency_not_early", out_valid, 0);
        cyc();
        check("latency_valid", out_valid, 1);
        check("ramp_values", out_pixel, 24'h0884FF);
        cyc();

        // Masked write to channel 1 only, then bypass ignores the table.
        write_lut(5'd16, 8'h10, 3'b010);
        send({5'd16, 5'd16, 5'd16}, 1'b0);
        cyc();
        check("masked_write", out_pixel, 24'h841084);
        send({5'd16, 5'd16, 5'd16}, 1'b1);
        cyc();
        check("bypass_values", out_pixel, 24'h848484);
        write_lut(5'd20, 8'hAA, 3'b000);
        cyc();

        // Eight pixels with downstream back-pressure on cycles 3..6.
        for (int i = 0; i < 8; i++) pixs[i] = PW'($urandom);
        stall_cycles = 0;
        idx = 0;
        k   = 0;
        while (idx < 8 && k < 100) begin
            out_ready = !(k >= 3 && k <= 6);
            in_valid  = 1'b1;
            in_pixel  = pixs[idx];
            in_bypass = idx[0];
            @(negedge clk);
            if (in_ready) idx++;
            cyc();
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("stall_cycle_count", stall_cycles, 4);
        check("stream_drained", exp_q.size(), 0);

        // Same-cycle write and read of address 5: old value first, new value next.
        lut_we        = 1'b1;
        lut_addr      = 5'd5;
        lut_data      = 8'h55;
        lut_chan_mask = 3'b111;
        send({5'd5, 5'd5, 5'd5}, 1'b0);
        lut_we = 1'b0;
        cyc();
        check("rbw_old_value", out_pixel, 24'h292929);
        send({5'd5, 5'd5, 5'd5}, 1'b0);
        cyc();
        check("rbw_new_value", out_pixel, 24'h555555);
        cyc();

        // Randomized traffic with interleaved table writes and back-pressure.
        for (int i = 0; i < 300; i++) begin
            in_valid      = ($urandom_range(3) != 0);
            in_pixel      = PW'($urandom);
            in_bypass     = ($urandom_range(3) == 0);
            out_ready     = ($urandom_range(3) != 0);
            lut_we        = ($urandom_range(7) == 0);
            lut_chan_mask = CH'($urandom);
            lut_addr      = IB'($urandom);
            lut_data      = 8'($urandom);
            cyc();
        end
        in_valid  = 1'b0;
        lut_we    = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        check("random_drained", exp_q.size(), 0);

        // Reset with two pixels in flight after table edits.
        write_lut(5'd5, 8'h55, 3'b111);
        in_valid  = 1'b1;
        in_bypass = 1'b0;
        in_pixel  = {5'd3, 5'd2, 5'd1};
        cyc();
        in_pixel  = {5'd6, 5'd5, 5'd4};
        cyc();
        in_valid = 1'b0;
        check("inflight_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_lut_busy", lut_busy, 1);
        check("async_in_ready", in_ready, 0);
        cyc();
        do_init();
        send({5'd16, 5'd16, 5'd16}, 1'b0);
        cyc();
        check("revert_addr16", out_pixel, 24'h848484);
        send({5'd5, 5'd5, 5'd5}, 1'b0);
        cyc();
        check("revert_addr5", out_pixel, 24'h292929);
        repeat (3) cyc();
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
